// File: rtl/tdfc_vaxpy_stream.sv
// Streaming z[i] = a*x[i] + y[i] over valid/backpressure token streams with end-of-stream tokens.
// One scalar from stream a scales each vector; a 2-entry output buffer decouples downstream stalls.
module tdfc_vaxpy_stream #(
  parameter int W     = 16,
  parameter int SAT   = 1,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [W-1:0]     a_d,
  input  logic             a_e,
  input  logic             a_v,
  output logic             a_b,
  input  logic [W-1:0]     x_d,
  input  logic             x_e,
  input  logic             x_v,
  output logic             x_b,
  input  logic [W-1:0]     y_d,
  input  logic             y_e,
  input  logic             y_v,
  output logic             y_b,
  output logic [W-1:0]     z_d,
  output logic             z_e,
  output logic             z_v,
  input  logic             z_b,
  output logic [CNT_W-1:0] len,
  output logic             err
);

  typedef enum logic [1:0] {LOAD_A, RUN, ERR} state_t;

  localparam logic signed [2*W:0] MAX_V = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W:0] MIN_V = {{(W+2){1'b1}}, {(W-1){1'b0}}};

  state_t                state, state_nxt;
  logic signed [W-1:0]   scale;
  logic [CNT_W-1:0]      cnt;

  logic [W-1:0]          fifo_d [2];
  logic                  fifo_e [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            count;
  logic                  room;

  logic                  push, push_e, pop;
  logic [W-1:0]          push_d;
  logic                  load_scale, cnt_inc, len_load, err_set;

  logic signed [2*W-1:0] product;
  logic signed [2*W:0]   sum;
  logic [W-1:0]          result;

  logic                  x_data, x_eos, y_data, y_eos;

  // Input acceptance only looks at buffer occupancy, never at z_b, so no combinational path
  // runs from downstream backpressure to upstream backpressure.
  assign room   = (count != 2'd2);
  assign x_data = x_v & ~x_e;
  assign x_eos  = x_v & x_e;
  assign y_data = y_v & ~y_e;
  assign y_eos  = y_v & y_e;

  assign product = scale * $signed(x_d);
  assign sum     = {product[2*W-1], product} + {{(W+1){y_d[W-1]}}, y_d};

  always_comb begin
    result = sum[W-1:0];
    if (SAT != 0) begin
      if (sum > MAX_V) begin
        result = MAX_V[W-1:0];
      end else if (sum < MIN_V) begin
        result = MIN_V[W-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= LOAD_A;
    end else begin
      state <= state_nxt;
    end
  end

  // Reset forces every stream to stall so no token is consumed in the reset cycle.
  always_comb begin
    state_nxt  = state;
    a_b        = 1'b1;
    x_b        = 1'b1;
    y_b        = 1'b1;
    push       = 1'b0;
    push_d     = '0;
    push_e     = 1'b0;
    load_scale = 1'b0;
    cnt_inc    = 1'b0;
    len_load   = 1'b0;
    err_set    = 1'b0;
    if (!reset) begin
      case (state)
        LOAD_A: begin
          if (a_v && !a_e) begin
            a_b        = 1'b0;
            load_scale = 1'b1;
            state_nxt  = RUN;
          end else if (a_v && a_e && room) begin
            a_b    = 1'b0;
            push   = 1'b1;
            push_e = 1'b1;
          end
        end
        RUN: begin
          if (x_data && y_data && room) begin
            x_b     = 1'b0;
            y_b     = 1'b0;
            push    = 1'b1;
            push_d  = result;
            cnt_inc = 1'b1;
          end else if (x_eos && y_eos && room) begin
            x_b       = 1'b0;
            y_b       = 1'b0;
            push      = 1'b1;
            push_e    = 1'b1;
            len_load  = 1'b1;
            state_nxt = LOAD_A;
          end else if ((x_eos && y_data) || (x_data && y_eos)) begin
            err_set   = 1'b1;
            state_nxt = ERR;
          end
        end
        default: begin
          state_nxt = ERR;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      scale <= '0;
      cnt   <= '0;
      len   <= '0;
      err   <= 1'b0;
    end else begin
      if (load_scale) begin
        scale <= $signed(a_d);
        cnt   <= '0;
      end
      if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end
      if (len_load) begin
        len <= cnt;
      end
      if (err_set) begin
        err <= 1'b1;
      end
    end
  end

  assign z_v = (count != 2'd0) & ~reset;
  assign z_d = z_v ? fifo_d[rd_ptr] : '0;
  assign z_e = z_v & fifo_e[rd_ptr];
  assign pop = z_v & ~z_b;

  // Two-entry ring buffer; push never happens when full, so count stays within 0..2.
  always_ff @(posedge clock) begin
    if (reset) begin
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      fifo_d[0] <= '0;
      fifo_d[1] <= '0;
      fifo_e[0] <= 1'b0;
      fifo_e[1] <= 1'b0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr] <= push_d;
        fifo_e[wr_ptr] <= push_e;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_tdfc_vaxpy_stream.sv
// Directed bench for tdfc_vaxpy_stream: a saturating and a wrapping instance share all inputs.
// Inputs change 1ns after each rising edge; outputs are sampled before the next edge.
module tb_tdfc_vaxpy_stream;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] a_d, x_d, y_d;
  logic        a_e, a_v, x_e, x_v, y_e, y_v, z_b;

  logic        a_b, x_b, y_b, z_e, z_v, err;
  logic [15:0] z_d, len;
  logic        a_b_w, x_b_w, y_b_w, z_e_w, z_v_w, err_w;
  logic [15:0] z_d_w, len_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  tdfc_vaxpy_stream #(.W(16), .SAT(1), .CNT_W(16)) u_sat (
    .clock(clock), .reset(reset),
    .a_d(a_d), .a_e(a_e), .a_v(a_v), .a_b(a_b),
    .x_d(x_d), .x_e(x_e), .x_v(x_v), .x_b(x_b),
    .y_d(y_d), .y_e(y_e), .y_v(y_v), .y_b(y_b),
    .z_d(z_d), .z_e(z_e), .z_v(z_v), .z_b(z_b),
    .len(len), .err(err)
  );

  tdfc_vaxpy_stream #(.W(16), .SAT(0), .CNT_W(16)) u_wrap (
    .clock(clock), .reset(reset),
    .a_d(a_d), .a_e(a_e), .a_v(a_v), .a_b(a_b_w),
    .x_d(x_d), .x_e(x_e), .x_v(x_v), .x_b(x_b_w),
    .y_d(y_d), .y_e(y_e), .y_v(y_v), .y_b(y_b_w),
    .z_d(z_d_w), .z_e(z_e_w), .z_v(z_v_w), .z_b(z_b),
    .len(len_w), .err(err_w)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_a(input logic v, input logic e, input logic [15:0] d);
    a_v = v; a_e = e; a_d = d;
  endtask

  task automatic set_xy(input logic v, input logic e, input logic [15:0] xd, input logic [15:0] yd);
    x_v = v; x_e = e; x_d = xd;
    y_v = v; y_e = e; y_d = yd;
  endtask

  task automatic idle();
    set_a(1'b0, 1'b0, 16'h0);
    set_xy(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_a(1'b1, 1'b0, 16'h0005);
    set_xy(1'b1, 1'b0, 16'h0001, 16'h0002);
    #1;
    n_checks++;
    if ({a_b, x_b, y_b} !== 3'b111) begin
      n_fail++; $display("[TB] FAIL reset_b: got %b expected 111", {a_b, x_b, y_b});
    end
    tick();
    n_checks++;
    if ({z_v, z_e, z_d, len, err} !== 35'h0) begin
      n_fail++; $display("[TB] FAIL reset_out: got v=%b e=%b d=%h len=%0d err=%b expected all 0",
                         z_v, z_e, z_d, len, err);
    end
    idle();
    reset = 1'b0;
    #1;
    n_checks++;
    if ({a_b, x_b, y_b, z_v} !== 4'b1110) begin
      n_fail++; $display("[TB] FAIL after_reset: got b=%b z_v=%b expected 111/0", {a_b, x_b, y_b}, z_v);
    end
  endtask

  task automatic test_stream();
    logic [15:0] xs [4];
    logic [15:0] ys [4];
    logic [15:0] zs [3];
    xs = '{16'd1, 16'd2, 16'd3, 16'd0};
    ys = '{16'd10, 16'd20, 16'd30, 16'd0};
    zs = '{16'd13, 16'd26, 16'd39};
    z_b = 1'b0;
    set_a(1'b1, 1'b0, 16'd3);
    #1;
    n_checks++;
    if (a_b !== 1'b0) begin
      n_fail++; $display("[TB] FAIL stream_a_take: got a_b=%b expected 0", a_b);
    end
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      set_xy(1'b1, i == 3, xs[i], ys[i]);
      #1;
      n_checks++;
      if ({x_b, y_b} !== 2'b00) begin
        n_fail++; $display("[TB] FAIL stream_take[%0d]: got %b expected 00", i, {x_b, y_b});
      end
      if (i > 0) begin
        n_checks++;
        if (z_v !== 1'b1 || z_e !== 1'b0 || z_d !== zs[i-1]) begin
          n_fail++; $display("[TB] FAIL stream_z[%0d]: got v=%b e=%b d=%0d expected 1/0/%0d",
                             i - 1, z_v, z_e, z_d, zs[i-1]);
        end
      end
      tick();
    end
    idle();
    #1;
    n_checks++;
    if (z_v !== 1'b1 || z_e !== 1'b1 || z_d !== 16'h0 || len !== 16'd3) begin
      n_fail++; $display("[TB] FAIL stream_eos: got v=%b e=%b d=%h len=%0d expected 1/1/0/3",
                         z_v, z_e, z_d, len);
    end
    tick();
    n_checks++;
    if (z_v !== 1'b0) begin
      n_fail++; $display("[TB] FAIL stream_empty: got z_v=%b expected 0", z_v);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] xs [4];
    logic [15:0] ys [4];
    logic [15:0] ed [4];
    logic        ee [4];
    int idx = 0;
    int n_out = 0;
    int cyc = 0;
    xs = '{16'd1, 16'd2, 16'd3, 16'd0};
    ys = '{16'd10, 16'd20, 16'd30, 16'd0};
    ed = '{16'd13, 16'd26, 16'd39, 16'd0};
    ee = '{1'b0, 1'b0, 1'b0, 1'b1};
    z_b = 1'b1;
    set_a(1'b1, 1'b0, 16'd3);
    tick();
    idle();
    while (n_out < 4 && cyc < 40) begin
      if (cyc == 5) z_b = 1'b0;
      if (idx < 4) set_xy(1'b1, idx == 3, xs[idx], ys[idx]);
      else set_xy(1'b0, 1'b0, 16'h0, 16'h0);
      #1;
      if (cyc == 4) begin
        n_checks++;
        if (idx != 2 || {x_b, y_b} !== 2'b11 || z_v !== 1'b1 || z_d !== 16'd13) begin
          n_fail++; $display("[TB] FAIL bp_hold: got taken=%0d b=%b z_v=%b z_d=%0d expected 2/11/1/13",
                             idx, {x_b, y_b}, z_v, z_d);
        end
      end
      if (z_v === 1'b1 && z_b === 1'b0) begin
        n_checks++;
        if (z_d !== ed[n_out] || z_e !== ee[n_out]) begin
          n_fail++; $display("[TB] FAIL bp_out[%0d]: got d=%0d e=%b expected d=%0d e=%b",
                             n_out, z_d, z_e, ed[n_out], ee[n_out]);
        end
        n_out++;
      end
      if (idx < 4 && x_b === 1'b0) idx++;
      tick();
      cyc++;
    end
    idle();
    #1;
    n_checks++;
    if (n_out != 4 || z_v !== 1'b0 || len !== 16'd3) begin
      n_fail++; $display("[TB] FAIL bp_end: got outs=%0d z_v=%b len=%0d expected 4/0/3", n_out, z_v, len);
    end
  endtask

  task automatic test_saturation();
    z_b = 1'b0;
    set_a(1'b1, 1'b0, 16'h4000);
    tick();
    idle();
    set_xy(1'b1, 1'b0, 16'd4, 16'h7FFF);
    tick();
    set_xy(1'b1, 1'b1, 16'h0, 16'h0);
    #1;
    n_checks++;
    if (z_v !== 1'b1 || z_d !== 16'h7FFF || z_v_w !== 1'b1 || z_d_w !== 16'h7FFF) begin
      n_fail++; $display("[TB] FAIL sat_pos: got sat=%h wrap=%h expected 7fff/7fff", z_d, z_d_w);
    end
    tick();
    idle();
    set_a(1'b1, 1'b0, 16'h8000);
    tick();
    idle();
    set_xy(1'b1, 1'b0, 16'd2, 16'd0);
    tick();
    set_xy(1'b1, 1'b0, 16'hFFFF, 16'd5);
    #1;
    n_checks++;
    if (z_d !== 16'h8000 || z_d_w !== 16'h0000) begin
      n_fail++; $display("[TB] FAIL sat_neg: got sat=%h wrap=%h expected 8000/0000", z_d, z_d_w);
    end
    tick();
    set_xy(1'b1, 1'b1, 16'h0, 16'h0);
    #1;
    n_checks++;
    if (z_d !== 16'h7FFF || z_d_w !== 16'h8005) begin
      n_fail++; $display("[TB] FAIL sat_negscale: got sat=%h wrap=%h expected 7fff/8005", z_d, z_d_w);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_misalign();
    z_b = 1'b1;
    set_a(1'b1, 1'b0, 16'd1);
    tick();
    idle();
    set_xy(1'b1, 1'b0, 16'd7, 16'd8);
    tick();
    x_v = 1'b1; x_e = 1'b1; x_d = 16'h0;
    y_v = 1'b1; y_e = 1'b0; y_d = 16'd5;
    #1;
    n_checks++;
    if ({x_b, y_b} !== 2'b11 || err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL mis_detect: got b=%b err=%b expected 11/0", {x_b, y_b}, err);
    end
    tick();
    z_b = 1'b0;
    set_xy(1'b1, 1'b0, 16'd1, 16'd1);
    set_a(1'b1, 1'b0, 16'd1);
    #1;
    n_checks++;
    if (err !== 1'b1 || {a_b, x_b, y_b} !== 3'b111 || z_v !== 1'b1 || z_d !== 16'd15) begin
      n_fail++; $display("[TB] FAIL mis_err: got err=%b b=%b z_v=%b z_d=%0d expected 1/111/1/15",
                         err, {a_b, x_b, y_b}, z_v, z_d);
    end
    tick();
    n_checks++;
    if (z_v !== 1'b0 || err !== 1'b1 || {a_b, x_b, y_b} !== 3'b111) begin
      n_fail++; $display("[TB] FAIL mis_drain: got z_v=%b err=%b b=%b expected 0/1/111",
                         z_v, err, {a_b, x_b, y_b});
    end
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL mis_clear: got err=%b expected 0", err);
    end
  endtask

  task automatic test_reset_mid();
    z_b = 1'b0;
    set_a(1'b1, 1'b0, 16'd2);
    tick();
    idle();
    set_xy(1'b1, 1'b0, 16'd1, 16'd1);
    tick();
    set_xy(1'b1, 1'b1, 16'd0, 16'd0);
    tick();
    idle();
    tick();
    n_checks++;
    if (len !== 16'd1 || z_v !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rmid_pre: got len=%0d z_v=%b expected 1/0", len, z_v);
    end
    z_b = 1'b1;
    set_a(1'b1, 1'b0, 16'd2);
    tick();
    idle();
    set_xy(1'b1, 1'b0, 16'd1, 16'd1);
    tick();
    set_xy(1'b1, 1'b0, 16'd2, 16'd2);
    tick();
    set_xy(1'b1, 1'b0, 16'd3, 16'd3);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({x_b, y_b} !== 2'b11 || z_v !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rmid_during: got b=%b z_v=%b expected 11/0", {x_b, y_b}, z_v);
    end
    tick();
    reset = 1'b0;
    idle();
    z_b = 1'b0;
    #1;
    n_checks++;
    if (z_v !== 1'b0 || len !== 16'd0) begin
      n_fail++; $display("[TB] FAIL rmid_after: got z_v=%b len=%0d expected 0/0", z_v, len);
    end
    set_a(1'b1, 1'b0, 16'd5);
    tick();
    idle();
    set_xy(1'b1, 1'b0, 16'd3, 16'd4);
    tick();
    set_xy(1'b1, 1'b1, 16'd0, 16'd0);
    #1;
    n_checks++;
    if (z_v !== 1'b1 || z_e !== 1'b0 || z_d !== 16'd19) begin
      n_fail++; $display("[TB] FAIL rmid_fresh: got v=%b e=%b d=%0d expected 1/0/19", z_v, z_e, z_d);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (z_v !== 1'b1 || z_e !== 1'b1 || len !== 16'd1) begin
      n_fail++; $display("[TB] FAIL rmid_eos: got v=%b e=%b len=%0d expected 1/1/1", z_v, z_e, len);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int av [10]  = '{1, 0, 0, 0, 1, 0, 0, 1, 0, 0};
    int ad [10]  = '{1, 0, 0, 0, 2, 0, 0, 1, 0, 0};
    int xyv [10] = '{0, 1, 1, 1, 0, 1, 1, 0, 1, 0};
    int xye [10] = '{0, 0, 0, 1, 0, 0, 1, 0, 1, 0};
    int xd [10]  = '{0, 4, 5, 0, 0, 3, 0, 0, 0, 0};
    int yd [10]  = '{0, 1, 1, 0, 0, 3, 0, 0, 0, 0};
    int ezv [10] = '{0, 0, 1, 1, 1, 0, 1, 1, 0, 1};
    int eze [10] = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 1};
    int ezd [10] = '{0, 0, 5, 6, 0, 0, 9, 0, 0, 0};
    int elen [10] = '{-1, -1, -1, -1, 2, 2, -1, 1, 1, 0};
    z_b = 1'b0;
    set_a(1'b1, 1'b1, 16'h0);
    set_xy(1'b1, 1'b0, 16'd9, 16'd9);
    #1;
    n_checks++;
    if ({a_b, x_b, y_b} !== 3'b011) begin
      n_fail++; $display("[TB] FAIL term_take: got b=%b expected 011", {a_b, x_b, y_b});
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (z_v !== 1'b1 || z_e !== 1'b1 || z_d !== 16'h0) begin
      n_fail++; $display("[TB] FAIL term_eos: got v=%b e=%b d=%h expected 1/1/0", z_v, z_e, z_d);
    end
    tick();
    for (int i = 0; i < 10; i++) begin
      set_a(av[i] != 0, 1'b0, 16'(ad[i]));
      set_xy(xyv[i] != 0, xye[i] != 0, 16'(xd[i]), 16'(yd[i]));
      #1;
      n_checks++;
      if ((av[i] != 0 && a_b !== 1'b0) || (xyv[i] != 0 && {x_b, y_b} !== 2'b00)) begin
        n_fail++; $display("[TB] FAIL b2b_take[%0d]: got a_b=%b xy_b=%b expected consume", i, a_b, {x_b, y_b});
      end
      n_checks++;
      if (z_v !== (ezv[i] != 0) || (ezv[i] != 0 && (z_e !== (eze[i] != 0) || z_d !== 16'(ezd[i])))) begin
        n_fail++; $display("[TB] FAIL b2b_z[%0d]: got v=%b e=%b d=%0d expected v=%0d e=%0d d=%0d",
                           i, z_v, z_e, z_d, ezv[i], eze[i], ezd[i]);
      end
      if (elen[i] >= 0) begin
        n_checks++;
        if (len !== 16'(elen[i])) begin
          n_fail++; $display("[TB] FAIL b2b_len[%0d]: got %0d expected %0d", i, len, elen[i]);
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    z_b = 1'b0;
    idle();
    tick();
    tick();
    $display("[TB] starting directed tests");
    test_reset();
    test_stream();
    test_backpressure();
    test_saturation();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
